// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain bitstream loader.
package ccff_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ISO_PRE  = 3'd1,
      ST_LOAD     = 3'd2,
      ST_SHIFT    = 3'd3,
      ST_ISO_POST = 3'd4,
      ST_DONE     = 3'd5
   } ccff_ld_state_e;

   function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Holds one bitstream word and shifts it out LSB-first, tracking how many
// bits of the word are still to be sent so the final partial word stops early.
module ccff_word_serializer
   import ccff_loader_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int LEN_W  = $clog2(WORD_W + 1)
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              load,
   input  logic [WORD_W-1:0] data,
   input  logic [LEN_W-1:0]  len,
   input  logic              shift,
   output logic              out,
   output logic              last_bit
);

   logic [WORD_W-1:0] sreg;
   logic [LEN_W-1:0]  word_left;

   // Capture a new word on load, otherwise move one bit toward the output per shift.
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         sreg      <= '0;
         word_left <= '0;
      end else if (load) begin
         sreg      <= data;
         word_left <= len;
      end else if (shift) begin
         sreg <= {1'b0, sreg[WORD_W-1:1]};
         if (word_left != '0) begin
            word_left <= word_left - LEN_W'(1);
         end
      end
   end

   assign out      = sreg[0];
   assign last_bit = (word_left == LEN_W'(1));

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Front end of the configuration chain: takes words over valid/ready, feeds
// them bit-serially into ccff_head, and keeps fabric I/O isolated until the
// whole chain is loaded and a trailing guard interval has passed.
module ccff_bitstream_loader
   import ccff_loader_pkg::*;
#(
   parameter int WORD_W     = 32,
   parameter int CHAIN_LEN  = 1024,
   parameter int ISO_CYCLES = 4
) (
   input  logic                           prog_clk,
   input  logic                           pReset,
   input  logic                           start,
   input  logic [WORD_W-1:0]              cfg_data,
   input  logic                           cfg_valid,
   output logic                           cfg_ready,
   output logic                           ccff_head,
   input  logic                           ccff_tail,
   output logic                           IO_ISOL_N,
   output logic                           busy,
   output logic                           done,
   output logic [$clog2(CHAIN_LEN+1)-1:0] tail_ones
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int LEN_W = $clog2(WORD_W + 1);
   localparam int GRD_W = $clog2(ISO_CYCLES + 1);

   ccff_ld_state_e   state;
   logic [CNT_W-1:0] bit_cnt;
   logic [GRD_W-1:0] guard_cnt;
   logic [LEN_W-1:0] load_len;
   logic             load_word;
   logic             shift_word;
   logic             sreg_out;
   logic             last_bit;
   logic             busy_q;
   logic             done_q;
   logic             iso_n_q;

   // Length of the next word: a full word, or only what is left of the chain.
   always_comb begin
      load_len = LEN_W'(min32(32'(WORD_W), 32'(CHAIN_LEN) - 32'(bit_cnt)));
   end

   assign load_word  = (state == ST_LOAD) && cfg_valid;
   assign shift_word = (state == ST_SHIFT);

   ccff_word_serializer #(
      .WORD_W (WORD_W),
      .LEN_W  (LEN_W)
   ) u_serializer (
      .prog_clk (prog_clk),
      .pReset   (pReset),
      .load     (load_word),
      .data     (cfg_data),
      .len      (load_len),
      .shift    (shift_word),
      .out      (sreg_out),
      .last_bit (last_bit)
   );

   // Sequencer: guard interval, word fetch/shift loop, trailing guard, then release isolation.
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         guard_cnt <= '0;
         tail_ones <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         iso_n_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state     <= ST_ISO_PRE;
                  bit_cnt   <= '0;
                  guard_cnt <= '0;
                  tail_ones <= '0;
                  busy_q    <= 1'b1;
                  done_q    <= 1'b0;
                  iso_n_q   <= 1'b0;
               end
            end
            ST_ISO_PRE: begin
               if (guard_cnt == GRD_W'(ISO_CYCLES - 1)) begin
                  guard_cnt <= '0;
                  state     <= ST_LOAD;
               end else begin
                  guard_cnt <= guard_cnt + GRD_W'(1);
               end
            end
            ST_LOAD: begin
               if (cfg_valid) begin
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               bit_cnt   <= bit_cnt + CNT_W'(1);
               tail_ones <= tail_ones + CNT_W'(ccff_tail);
               if (last_bit) begin
                  if (bit_cnt == CNT_W'(CHAIN_LEN - 1)) begin
                     guard_cnt <= '0;
                     state     <= ST_ISO_POST;
                  end else begin
                     state <= ST_LOAD;
                  end
               end
            end
            ST_ISO_POST: begin
               if (guard_cnt == GRD_W'(ISO_CYCLES - 1)) begin
                  guard_cnt <= '0;
                  state     <= ST_DONE;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  iso_n_q   <= 1'b1;
               end else begin
                  guard_cnt <= guard_cnt + GRD_W'(1);
               end
            end
            default: begin
               state   <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               iso_n_q <= 1'b0;
            end
         endcase
      end
   end

   assign cfg_ready = (state == ST_LOAD);
   assign ccff_head = shift_word & sreg_out;
   assign busy      = busy_q;
   assign done      = done_q;
   assign IO_ISOL_N = iso_n_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for the bitstream loader: a 20-flop instance with a modelled
// chain on ccff_tail, plus an 8-flop instance for the single-word case.
module tb_ccff_bitstream_loader;

   logic        prog_clk = 1'b0;
   logic        pReset;
   logic        start;
   logic        cfg_valid;
   logic [7:0]  cfg_data;
   logic        use_small;
   logic        start_big;
   logic        start_small;
   logic        ccff_tail;

   logic        big_ready, big_head, big_iso, big_busy, big_done;
   logic [4:0]  big_tail_ones;
   logic        sm_ready, sm_head, sm_iso, sm_busy, sm_done;
   logic [3:0]  sm_tail_ones;

   logic        obs_ready, obs_head, obs_iso, obs_busy, obs_done;

   logic [19:0] chain = '0;
   logic        chain_en;
   logic [7:0]  words [0:2];

   int total = 0;
   int bad   = 0;

   always #5 prog_clk = ~prog_clk;

   assign start_big   = start & ~use_small;
   assign start_small = start & use_small;
   assign ccff_tail   = chain[19];

   assign obs_ready = use_small ? sm_ready : big_ready;
   assign obs_head  = use_small ? sm_head  : big_head;
   assign obs_iso   = use_small ? sm_iso   : big_iso;
   assign obs_busy  = use_small ? sm_busy  : big_busy;
   assign obs_done  = use_small ? sm_done  : big_done;

   // Model of the 20-flop configuration chain, clocked only while bits are expected.
   always @(posedge prog_clk) begin
      if (chain_en && !use_small) begin
         chain <= {chain[18:0], big_head};
      end
   end

   ccff_bitstream_loader #(
      .WORD_W     (8),
      .CHAIN_LEN  (20),
      .ISO_CYCLES (2)
   ) u_big (
      .prog_clk  (prog_clk),
      .pReset    (pReset),
      .start     (start_big),
      .cfg_data  (cfg_data),
      .cfg_valid (cfg_valid),
      .cfg_ready (big_ready),
      .ccff_head (big_head),
      .ccff_tail (ccff_tail),
      .IO_ISOL_N (big_iso),
      .busy      (big_busy),
      .done      (big_done),
      .tail_ones (big_tail_ones)
   );

   ccff_bitstream_loader #(
      .WORD_W     (8),
      .CHAIN_LEN  (8),
      .ISO_CYCLES (2)
   ) u_small (
      .prog_clk  (prog_clk),
      .pReset    (pReset),
      .start     (start_small),
      .cfg_data  (cfg_data),
      .cfg_valid (cfg_valid),
      .cfg_ready (sm_ready),
      .ccff_head (sm_head),
      .ccff_tail (1'b0),
      .IO_ISOL_N (sm_iso),
      .busy      (sm_busy),
      .done      (sm_done),
      .tail_ones (sm_tail_ones)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge prog_clk);
      #1;
   endtask

   // One programming run: pulse start, feed words, check every cycle until done.
   task automatic applyStimulus(input int clen, input int stall_cycles, input int poke_bit,
                                input int abort_bit, input int exp_edges);
      int         e;
      int         bi;
      int         left;
      int         wi;
      int         hs;
      int         stall_left;
      logic       hs_now;
      logic [7:0] w;
      e          = 0;
      bi         = 0;
      left       = 0;
      wi         = 0;
      hs         = 0;
      stall_left = stall_cycles;
      cfg_valid  = 1'b1;
      cfg_data   = words[0];
      start      = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("start_done_low", 32'(obs_done), 0);
      checkOutput("start_iso_low", 32'(obs_iso), 0);
      checkOutput("start_busy_high", 32'(obs_busy), 1);
      while (!obs_done && e < 400) begin
         start = 1'b0;
         if (left > 0) begin
            w = words[bi / 8];
            checkOutput("head_bit", 32'(obs_head), 32'(w[bi % 8]));
            checkOutput("ready_in_shift", 32'(obs_ready), 0);
            if (bi == abort_bit) begin
               chain_en = 1'b0;
               pReset   = 1'b1;
               #1;
               checkOutput("abort_head", 32'(big_head), 0);
               checkOutput("abort_ready", 32'(big_ready), 0);
               checkOutput("abort_iso", 32'(big_iso), 0);
               checkOutput("abort_busy", 32'(big_busy), 0);
               checkOutput("abort_done", 32'(big_done), 0);
               checkOutput("abort_tail_ones", 32'(big_tail_ones), 0);
               #1;
               pReset    = 1'b0;
               cfg_valid = 1'b0;
               return;
            end
            if (bi == poke_bit) begin
               start = 1'b1;
            end
            chain_en = 1'b1;
            bi++;
            left--;
         end else begin
            checkOutput("head_idle", 32'(obs_head), 0);
            chain_en = 1'b0;
         end
         checkOutput("iso_held", 32'(obs_iso), 0);
         checkOutput("busy_held", 32'(obs_busy), 1);
         if (obs_ready && wi == 1 && stall_left > 0) begin
            cfg_valid = 1'b0;
            stall_left--;
         end else begin
            cfg_valid = 1'b1;
         end
         hs_now = obs_ready && cfg_valid;
         if (hs_now) begin
            hs++;
            left = (clen - bi < 8) ? (clen - bi) : 8;
         end
         tick();
         e++;
         if (hs_now) begin
            wi++;
            if (wi < 3) begin
               cfg_data = words[wi];
            end
         end
      end
      chain_en  = 1'b0;
      cfg_valid = 1'b0;
      start     = 1'b0;
      checkOutput("done_edges", 32'(e), 32'(exp_edges));
      checkOutput("bits_shifted", 32'(bi), 32'(clen));
      checkOutput("handshakes", 32'(hs), 32'((clen + 7) / 8));
      checkOutput("end_done", 32'(obs_done), 1);
      checkOutput("end_iso", 32'(obs_iso), 1);
      checkOutput("end_busy", 32'(obs_busy), 0);
      checkOutput("end_head", 32'(obs_head), 0);
      checkOutput("end_ready", 32'(obs_ready), 0);
   endtask

   initial begin
      use_small = 1'b0;
      start     = 1'b0;
      cfg_valid = 1'b0;
      cfg_data  = '0;
      chain_en  = 1'b0;
      pReset    = 1'b1;
      #1;
      checkOutput("rst_head", 32'(big_head), 0);
      checkOutput("rst_ready", 32'(big_ready), 0);
      checkOutput("rst_iso", 32'(big_iso), 0);
      checkOutput("rst_busy", 32'(big_busy), 0);
      checkOutput("rst_done", 32'(big_done), 0);
      checkOutput("rst_tail_ones", 32'(big_tail_ones), 0);
      checkOutput("rst_small_iso", 32'(sm_iso), 0);
      #11;
      pReset = 1'b0;
      tick();

      $display("[TB] nominal load");
      words[0] = 8'hA5;
      words[1] = 8'h3C;
      words[2] = 8'h0F;
      applyStimulus(20, 0, -1, -1, 27);
      checkOutput("s1_tail_ones", 32'(big_tail_ones), 0);
      tick();
      tick();
      checkOutput("s1_done_level", 32'(big_done), 1);
      checkOutput("s1_iso_level", 32'(big_iso), 1);

      $display("[TB] stalled source");
      applyStimulus(20, 10, -1, -1, 37);

      $display("[TB] reset mid-shift");
      applyStimulus(20, 0, -1, 5, 0);
      tick();
      tick();
      checkOutput("s3_idle_busy", 32'(big_busy), 0);
      checkOutput("s3_idle_iso", 32'(big_iso), 0);
      applyStimulus(20, 0, -1, -1, 27);

      $display("[TB] start while busy, then re-program from done");
      applyStimulus(20, 0, 10, -1, 27);
      applyStimulus(20, 0, -1, -1, 27);

      $display("[TB] chain loopback");
      words[0] = 8'hFF;
      words[1] = 8'hFF;
      words[2] = 8'hFF;
      applyStimulus(20, 0, -1, -1, 27);
      checkOutput("s5_chain_ones", 32'(chain), 32'h000F_FFFF);
      words[0] = 8'h00;
      words[1] = 8'h00;
      words[2] = 8'h00;
      applyStimulus(20, 0, -1, -1, 27);
      checkOutput("s5_tail_ones", 32'(big_tail_ones), 20);
      checkOutput("s5_chain_zeros", 32'(chain), 0);

      $display("[TB] single-word chain");
      use_small = 1'b1;
      words[0]  = 8'h96;
      applyStimulus(8, 0, -1, -1, 13);
      checkOutput("s6_tail_ones", 32'(sm_tail_ones), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
